uart_slave: RTL and testbench
=============================

Name: uart_slave

Overview:
- Receive end of the in-house serial link driven by uart_master.
- Frame: start bit (0), 8 data bits LSB first, even-parity bit (XOR of data), trailer bit (0).
- Samples the line at mid-bit using a clock-per-bit counter.
- Delivers the byte through a one-entry holding register with valid/read handshake, parity/frame/overrun flags.

Parameters:
- clk_freq, 50000000, receiver clock frequency in Hz.
- baud_rate, 19200, line bit rate in bits per second.
- CLKS_PER_BIT (localparam), clk_freq/baud_rate (2604), clocks per line bit; must be >= 4.
- HALF (localparam), CLKS_PER_BIT/2, start-bit mid-point offset.

Ports:
- clk  input  1  receiver clock.
- rst  input  1  synchronous, active-high reset.
- u_rx  input  1  serial line from uart_master u_tx; idle high (board pull-up), asynchronous to clk.
- rd_en  input  1  consumer read strobe; clears u_rx_valid.
- u_rx_data  output  8  last received byte.
- u_rx_valid  output  1  holding register full.
- u_rx_parity_err  output  1  parity mismatch on the byte in u_rx_data.
- u_rx_frame_err  output  1  trailer bit sampled 1 on the byte in u_rx_data.
- u_rx_overrun  output  1  a frame completed while u_rx_valid was already 1.
- u_rx_busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Input path: u_rx passes through a 2-flop synchronizer, both flops reset to 1. All logic below uses the synchronized value rxs.
- Reset: state=IDLE, counters 0, u_rx_data=8'h00, all flags and u_rx_valid 0, u_rx_busy 0.
- Reset mid-frame discards the partial frame with no valid pulse.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). Bit index idx is 3 bits.
- State machine:
  - IDLE: when rxs==0, go to START with cnt=0.
  - START: count up. At cnt==HALF-1:
    - rxs==0: go to DATA with cnt=0, idx=0.
    - rxs==1: false start; go back to IDLE, no flags changed.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxs into the shift register at position idx and set cnt=0. After idx==7 go to PARITY, otherwise idx+1.
  - PARITY: at cnt==CLKS_PER_BIT-1, capture rxs as the parity bit, cnt=0, go to TRAILER.
  - TRAILER: at cnt==CLKS_PER_BIT-1, complete the frame and go to IDLE.
- Frame completion (all outputs registered, visible the cycle after the trailer sample):
  - Load u_rx_data from the shift register.
  - u_rx_parity_err = (^data != parity bit).
  - u_rx_frame_err = trailer sample.
  - u_rx_valid = 1.
  - u_rx_overrun = 1 if u_rx_valid was 1 and not being cleared by rd_en that same cycle; otherwise unchanged.
- Back-to-back frames: the master may start the next frame immediately after the trailer, so the line can stay 0. IDLE accepts a start on the level rxs==0; no high gap is required.
- Error frames still load data and assert valid; the flags qualify the byte.
- Read handshake:
  - rd_en with u_rx_valid=1 clears u_rx_valid, u_rx_overrun, u_rx_parity_err and u_rx_frame_err next cycle.
  - rd_en with u_rx_valid=0 is ignored.
  - rd_en in the same cycle as a frame completion: the new byte loads, u_rx_valid stays 1, no overrun, flags reflect the new frame.
- Overrun is sticky until rd_en. The newest byte overwrites the older one.
- Sampling instants: HALF + k*CLKS_PER_BIT clocks after start detection in rxs, k = 1..10.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, TRAILER), 3 bits.
  - DATA_BITS=8.
  - Default clk_freq and baud_rate constants, shared with uart_master.
- Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1. Everything else stays in uart_slave.

Test Plan:
- All tests use clk_freq=160 and baud_rate=10 (CLKS_PER_BIT=16, HALF=8); line idles at 1.
- Byte 0xA5, parity 0, trailer 0 -> u_rx_data=A5, u_rx_valid=1, no flags, u_rx_busy low after the frame; valid held until rd_en, cleared the next cycle.
- Byte 0x01 sent with parity 0 (correct is 1) -> u_rx_data=01, u_rx_parity_err=1, u_rx_frame_err=0.
- Byte 0x7E sent with trailer 1 -> u_rx_frame_err=1, u_rx_parity_err=0.
- Line low for 3 clocks, then high -> u_rx_busy pulses and returns to 0; no valid, data stays 00.
- Frames 0x3C then 0xC3 back-to-back with line kept 0 between trailer and start, no rd_en -> u_rx_data=C3, u_rx_overrun=1. Repeat with rd_en coincident with the second completion -> valid=1, overrun=0.
- rst asserted for 1 clock mid-DATA of 0xFF -> all outputs reset, no valid. The following frame 0x5A is received with no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the in-house UART link (uart_master / uart_slave).
// Types and constants only: no latency, no flow control.
package uart_pkg;

   localparam int DATA_BITS         = 8;
   localparam int DEFAULT_CLK_FREQ  = 50_000_000;
   localparam int DEFAULT_BAUD_RATE = 19_200;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      TRAILER = 3'd4
   } rx_state_t;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; 2 clk latency, no backpressure.
// Both flops reset to 1 so a held reset looks like an idle line.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_slave.sv
// UART receiver with one-entry holding register; byte visible the cycle after the trailer sample.
// No backpressure: an unread byte is overwritten by the next frame and flagged as overrun.
module uart_slave
   import uart_pkg::*;
#(
   parameter int clk_freq  = DEFAULT_CLK_FREQ,
   parameter int baud_rate = DEFAULT_BAUD_RATE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 u_rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] u_rx_data,
   output logic                 u_rx_valid,
   output logic                 u_rx_parity_err,
   output logic                 u_rx_frame_err,
   output logic                 u_rx_overrun,
   output logic                 u_rx_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   logic                 rxs;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 frame_done;
   logic                 rd_ack;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (u_rx),
      .q   (rxs)
   );

   // Start is accepted on level, so a trailer running straight into the next start bit is fine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         u_rx_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state     <= START;
                  cnt       <= '0;
                  u_rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  cnt <= '0;
                  idx <= '0;
                  if (!rxs) begin
                     state <= DATA;
                  end else begin
                     state     <= IDLE;
                     u_rx_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= rxs;
                  if (idx == IDX_LAST) begin
                     state <= PARITY;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  par_bit <= rxs;
                  state   <= TRAILER;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            TRAILER: begin
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  state     <= IDLE;
                  u_rx_busy <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               u_rx_busy <= 1'b0;
            end
         endcase
      end
   end

   assign frame_done = (state == TRAILER) && (cnt == CNT_LAST);
   assign rd_ack     = rd_en && u_rx_valid;

   // A read coinciding with completion consumes the old byte, so the new one is not an overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         u_rx_data       <= '0;
         u_rx_valid      <= 1'b0;
         u_rx_parity_err <= 1'b0;
         u_rx_frame_err  <= 1'b0;
         u_rx_overrun    <= 1'b0;
      end else if (frame_done) begin
         u_rx_data       <= shreg;
         u_rx_valid      <= 1'b1;
         u_rx_parity_err <= (^shreg) != par_bit;
         u_rx_frame_err  <= rxs;
         if (u_rx_valid && !rd_en) begin
            u_rx_overrun <= 1'b1;
         end else if (rd_ack) begin
            u_rx_overrun <= 1'b0;
         end
      end else if (rd_ack) begin
         u_rx_valid      <= 1'b0;
         u_rx_parity_err <= 1'b0;
         u_rx_frame_err  <= 1'b0;
         u_rx_overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_slave.sv
// Scenario bench for uart_slave at 16 clocks per bit with a transaction-level reference model.
module tb_uart_slave;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   // Line edge to start detection: two synchronizer flops plus the IDLE sampling edge.
   localparam int DETECT_J = 3;
   localparam int DONE_J   = DETECT_J + HALF + 10 * CPB;
   // Second frame of a back-to-back pair: detection is the first IDLE cycle after completion.
   localparam int B2B_DONE = DONE_J + 1 + HALF + 10 * CPB;

   logic       clk;
   logic       rst;
   logic       u_rx;
   logic       rd_en;
   logic [7:0] u_rx_data;
   logic       u_rx_valid;
   logic       u_rx_parity_err;
   logic       u_rx_frame_err;
   logic       u_rx_overrun;
   logic       u_rx_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] m_data;
   logic       m_valid, m_perr, m_ferr, m_ovr;

   logic [12:0] obs;
   assign obs = {u_rx_data, u_rx_valid, u_rx_parity_err, u_rx_frame_err, u_rx_overrun, u_rx_busy};

   uart_slave #(.clk_freq(160), .baud_rate(10)) dut (
      .clk             (clk),
      .rst             (rst),
      .u_rx            (u_rx),
      .rd_en           (rd_en),
      .u_rx_data       (u_rx_data),
      .u_rx_valid      (u_rx_valid),
      .u_rx_parity_err (u_rx_parity_err),
      .u_rx_frame_err  (u_rx_frame_err),
      .u_rx_overrun    (u_rx_overrun),
      .u_rx_busy       (u_rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic t);
      return {t, p, d, 1'b0};
   endfunction

   function automatic logic [12:0] expv(input logic busy);
      return {m_data, m_valid, m_perr, m_ferr, m_ovr, busy};
   endfunction

   task automatic model_reset();
      m_data = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_complete(input logic [7:0] d, input logic p, input logic t, input logic rd);
      if (m_valid) m_ovr = !rd;
      m_data  = d;
      m_perr  = (^d) != p;
      m_ferr  = t;
      m_valid = 1'b1;
   endtask

   task automatic model_read();
      if (m_valid) begin
         m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      end
   endtask

   task automatic do_reset();
      u_rx = 1'b1; rd_en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic drive_line(input logic [21:0] bits, input int nbits, input int rd_j);
      for (int j = 0; j < nbits * CPB; j++) begin
         u_rx  = bits[j / CPB];
         rd_en = (j == rd_j);
         tick();
      end
      u_rx = 1'b1; rd_en = 1'b0;
   endtask

   task automatic send_and_settle(input logic [7:0] d, input logic p, input logic t);
      drive_line({11'h7FF, frame(d, p, t)}, 11, -1);
      repeat (24) tick();
      model_complete(d, p, t, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; u_rx = 1'b1; rd_en = 1'b0;
      repeat (3) tick();
      model_reset();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL reset_held: got %h want %h", obs, expv(1'b0));
      end
      rst = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL reset_idle: got %h want %h", obs, expv(1'b0));
      end
   endtask

   task automatic test_false_start();
      u_rx = 1'b0;
      repeat (3) tick();
      u_rx = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if (u_rx_busy !== 1'b1) begin
         n_fail++; $display("FAIL false_start_busy: got %b want 1", u_rx_busy);
      end
      repeat (20) tick();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL false_start_after: got %h want %h", obs, expv(1'b0));
      end
   endtask

   task automatic test_basic();
      logic [10:0] f;
      f = frame(8'hA5, 1'b0, 1'b0);
      for (int j = 0; j < 11 * CPB; j++) begin
         u_rx = f[j / CPB];
         tick();
         if (j + 1 == DETECT_J - 1) begin
            n_cmp++;
            if (u_rx_busy !== 1'b0) begin
               n_fail++; $display("FAIL basic_busy_before: got %b want 0", u_rx_busy);
            end
         end
         if (j + 1 == DETECT_J) begin
            n_cmp++;
            if (u_rx_busy !== 1'b1) begin
               n_fail++; $display("FAIL basic_busy_start: got %b want 1", u_rx_busy);
            end
         end
         if (j + 1 == DONE_J - 1) begin
            n_cmp++;
            if (u_rx_valid !== 1'b0) begin
               n_fail++; $display("FAIL basic_valid_early: got %b want 0", u_rx_valid);
            end
         end
         if (j + 1 == DONE_J) begin
            model_complete(8'hA5, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs[12:1] !== expv(1'b0) >> 1) begin
               n_fail++; $display("FAIL basic_complete: got %h want %h", obs[12:1], expv(1'b0) >> 1);
            end
         end
      end
      u_rx = 1'b1;
      repeat (30) tick();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL basic_held: got %h want %h", obs, expv(1'b0));
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      model_read();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL basic_read: got %h want %h", obs, expv(1'b0));
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL basic_read_empty: got %h want %h", obs, expv(1'b0));
      end
   endtask

   task automatic test_parity_err();
      send_and_settle(8'h01, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL parity_err: got %h want %h", obs, expv(1'b0));
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      model_read();
   endtask

   task automatic test_frame_err();
      send_and_settle(8'h7E, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL frame_err: got %h want %h", obs, expv(1'b0));
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      model_read();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL frame_err_read: got %h want %h", obs, expv(1'b0));
      end
   endtask

   task automatic test_back_to_back(input logic rd_at_second);
      do_reset();
      drive_line({frame(8'hC3, 1'b0, 1'b0), frame(8'h3C, 1'b0, 1'b0)}, 22,
                 rd_at_second ? B2B_DONE - 1 : -1);
      model_complete(8'h3C, 1'b0, 1'b0, 1'b0);
      model_complete(8'hC3, 1'b0, 1'b0, rd_at_second);
      // The trailing 0 legitimately re-arms the receiver, so busy is left out here.
      n_cmp++;
      if (obs[12:1] !== expv(1'b0) >> 1) begin
         n_fail++; $display("FAIL back_to_back rd=%0b: got %h want %h",
                            rd_at_second, obs[12:1], expv(1'b0) >> 1);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_frame();
      logic [10:0] f;
      send_and_settle(8'h11, 1'b0, 1'b0);
      f = frame(8'hFF, 1'b0, 1'b0);
      for (int j = 0; j < CPB + 3 * CPB + 5; j++) begin
         u_rx = f[j / CPB];
         tick();
      end
      rst = 1'b1; tick(); rst = 1'b0;
      u_rx = 1'b1;
      model_reset();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL mid_frame_reset: got %h want %h", obs, expv(1'b0));
      end
      repeat (40) tick();
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL mid_frame_quiet: got %h want %h", obs, expv(1'b0));
      end
      send_and_settle(8'h5A, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== expv(1'b0)) begin
         n_fail++; $display("FAIL after_reset_frame: got %h want %h", obs, expv(1'b0));
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       p, t;
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         p = (^d) ^ ($urandom_range(0, 3) == 0);
         t = ($urandom_range(0, 3) == 0);
         send_and_settle(d, p, t);
         n_cmp++;
         if (obs !== expv(1'b0)) begin
            n_fail++; $display("FAIL random[%0d] d=%h: got %h want %h", i, d, obs, expv(1'b0));
         end
         if ($urandom_range(0, 1) == 1) begin
            rd_en = 1'b1; tick(); rd_en = 1'b0;
            model_read();
            n_cmp++;
            if (obs !== expv(1'b0)) begin
               n_fail++; $display("FAIL random_read[%0d]: got %h want %h", i, obs, expv(1'b0));
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; u_rx = 1'b1; rd_en = 1'b0;
      model_reset();
      test_reset();
      test_false_start();
      test_basic();
      test_parity_err();
      test_frame_err();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
